// File: rtl/ram_pkg.sv
// Shared types and helpers for the handshaked RAM bank.
package ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Word storage with per-byte synchronous write and registered read.
module ram_core
  import ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 128,
  parameter int    IDX_W     = 7,
  parameter string INIT_FILE = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic                  i_re,
  input  logic                  i_rclr,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]     i_din,
  output logic [DATA_W-1:0]     o_dout
);

  localparam int NB = lanes(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_din[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_dout <= '0;
    else if (i_rclr) r_dout <= '0;
    else if (i_re)   r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/ram_hs_bank.sv
// Request/ack RAM bank: request capture, wait-state counter, range check, single-cycle ack.
module ram_hs_bank
  import ram_pkg::*;
#(
  parameter int    ADDR_W    = 20,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 128,
  parameter int    OUT_W     = 48,
  parameter int    WAIT_CYC  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [DATA_W-1:0]   dina,
  output logic [OUT_W-1:0]    douta,
  output logic                ack,
  output logic                busy,
  output logic                err
);

  localparam int NB    = lanes(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_we;
  logic [DATA_W-1:0] r_din;
  logic              r_ack, r_busy, r_err;
  logic              w_accept, w_commit, w_in_range, w_is_wr;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept   = (r_state == ST_IDLE) && req;
  assign w_commit   = (r_state == ST_DONE) && !rst;
  assign w_in_range = {1'b0, r_addr} < (ADDR_W+1)'(DEPTH);
  assign w_is_wr    = |r_we;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_CYC - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy stays up through the ack cycle; a new accept in IDLE re-raises it seamlessly.
  always_ff @(posedge clka) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_din   <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= addra;
        r_we   <= wea;
        r_din  <= dina;
      end
      r_ack  <= w_commit;
      r_busy <= (r_state == ST_IDLE) ? req : 1'b1;
      if (w_commit) r_err <= !w_in_range;
    end
  end

  ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .i_clk  (clka),
    .i_rst  (rst),
    .i_we   (r_we & {NB{w_commit && w_in_range}}),
    .i_re   (w_commit && !w_is_wr && w_in_range),
    .i_rclr (w_commit && !w_is_wr && !w_in_range),
    .i_addr (r_addr[IDX_W-1:0]),
    .i_din  (r_din),
    .o_dout (w_rdata)
  );

  assign douta = OUT_W'(w_rdata);
  assign ack   = r_ack;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_ram_hs_bank.sv
// Scoreboarded bench for ram_hs_bank: three instances (default, 3 wait states, 64-bit/16-deep/5 wait states).
module tb_ram_hs_bank;

  typedef struct {
    logic [63:0] dout;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_a, ack_a, busy_a, err_a;
  logic [19:0] addr_a;
  logic [3:0]  wea_a;
  logic [31:0] din_a;
  logic [47:0] dout_a;

  logic        req_b, ack_b, busy_b, err_b;
  logic [19:0] addr_b;
  logic [3:0]  wea_b;
  logic [31:0] din_b;
  logic [47:0] dout_b;

  logic        req_c, ack_c, busy_c, err_c;
  logic [19:0] addr_c;
  logic [7:0]  wea_c;
  logic [63:0] din_c;
  logic [63:0] dout_c;

  ram_hs_bank u_a (
    .clka(clk), .rst(rst), .req(req_a), .addra(addr_a), .wea(wea_a), .dina(din_a),
    .douta(dout_a), .ack(ack_a), .busy(busy_a), .err(err_a));

  ram_hs_bank #(.WAIT_CYC(3)) u_b (
    .clka(clk), .rst(rst), .req(req_b), .addra(addr_b), .wea(wea_b), .dina(din_b),
    .douta(dout_b), .ack(ack_b), .busy(busy_b), .err(err_b));

  ram_hs_bank #(.DATA_W(64), .OUT_W(64), .DEPTH(16), .WAIT_CYC(5)) u_c (
    .clka(clk), .rst(rst), .req(req_c), .addra(addr_c), .wea(wea_c), .dina(din_c),
    .douta(dout_c), .ack(ack_c), .busy(busy_c), .err(err_c));

  int checks = 0;
  int failures = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;
  logic [63:0] mem_m [3][128];
  logic [63:0] last_m [3];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] we);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (we[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  function automatic logic get_ack(input int inst);
    case (inst)
      0: return ack_a;
      1: return ack_b;
      default: return ack_c;
    endcase
  endfunction

  // Scoreboard consumers: one per instance, popping on every ack.
  always @(posedge clk) begin
    #1;
    if (ack_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++; $display("FAIL unexpected_ack_a ack=1 expected no ack");
      end else begin
        e_a = q_a.pop_front();
        if ({16'h0, dout_a} !== e_a.dout || err_a !== e_a.err) begin
          failures++;
          $display("FAIL %s douta=%h err=%b expected douta=%h err=%b",
                   e_a.name, dout_a, err_a, e_a.dout[47:0], e_a.err);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ack_b === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++; $display("FAIL unexpected_ack_b ack=1 expected no ack");
      end else begin
        e_b = q_b.pop_front();
        if ({16'h0, dout_b} !== e_b.dout || err_b !== e_b.err) begin
          failures++;
          $display("FAIL %s douta=%h err=%b expected douta=%h err=%b",
                   e_b.name, dout_b, err_b, e_b.dout[47:0], e_b.err);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (ack_c === 1'b1) begin
      checks++;
      if (q_c.size() == 0) begin
        failures++; $display("FAIL unexpected_ack_c ack=1 expected no ack");
      end else begin
        e_c = q_c.pop_front();
        if (dout_c !== e_c.dout || err_c !== e_c.err) begin
          failures++;
          $display("FAIL %s douta=%h err=%b expected douta=%h err=%b",
                   e_c.name, dout_c, err_c, e_c.dout, e_c.err);
        end
      end
    end
  end

  task automatic drive(input int inst, input logic r, input logic [19:0] addr,
                       input logic [7:0] we, input logic [63:0] din);
    case (inst)
      0: begin req_a = r; addr_a = addr; wea_a = we[3:0]; din_a = din[31:0]; end
      1: begin req_b = r; addr_b = addr; wea_b = we[3:0]; din_b = din[31:0]; end
      default: begin req_c = r; addr_c = addr; wea_c = we; din_c = din; end
    endcase
  endtask

  // Model the access, queue the expected result, then issue one request and wait for ack.
  task automatic expect_push(input int inst, input logic [19:0] addr, input logic [7:0] we,
                             input logic [63:0] din, input string name);
    exp_t e;
    int depth;
    depth = (inst == 2) ? 16 : 128;
    e.name = name;
    e.err  = (addr >= depth);
    if (we == 8'h0) begin
      e.dout = e.err ? 64'h0 : mem_m[inst][addr];
      last_m[inst] = e.dout;
    end else begin
      e.dout = last_m[inst];
      if (!e.err) mem_m[inst][addr] = merge(mem_m[inst][addr], din, we);
    end
    case (inst)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic access(input int inst, input logic [19:0] addr, input logic [7:0] we,
                        input logic [63:0] din, input string name, output int lat);
    expect_push(inst, addr, we, din, name);
    @(negedge clk); drive(inst, 1'b1, addr, we, din);
    @(negedge clk); drive(inst, 1'b0, addr, we, din);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (get_ack(inst) === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat < 0) begin failures++; $display("FAIL %s_timeout ack never seen within 12 cycles", name); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout_a !== 48'h0) begin failures++; $display("FAIL rst_douta got=%h exp=0", dout_a); end
    checks++; if (ack_a !== 1'b0)   begin failures++; $display("FAIL rst_ack got=%b exp=0", ack_a); end
    checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
    checks++; if (err_a !== 1'b0)   begin failures++; $display("FAIL rst_err got=%b exp=0", err_a); end
    checks++; if (busy_b !== 1'b0 || ack_b !== 1'b0) begin failures++; $display("FAIL rst_b busy=%b ack=%b exp=0", busy_b, ack_b); end
    checks++; if (dout_c !== 64'h0) begin failures++; $display("FAIL rst_douta_c got=%h exp=0", dout_c); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) last_m[i] = 64'h0;
  endtask

  task automatic test_basic_rw;
    int lat;
    access(0, 20'd5, 8'h0F, 64'hDEADBEEF, "wr5", lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    access(0, 20'd5, 8'h00, 64'h0, "rd5", lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rd_latency got=%0d exp=1", lat); end
    checks++; if (dout_a !== 48'h0000_DEADBEEF) begin failures++; $display("FAIL rd5_value got=%h exp=0000deadbeef", dout_a); end
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0 || ack_a !== 1'b0) begin failures++; $display("FAIL post_ack busy=%b ack=%b exp=0", busy_a, ack_a); end
  endtask

  task automatic test_byte_write;
    int lat;
    access(0, 20'd3, 8'h0F, 64'hAABBCCDD, "wr3_full", lat);
    access(0, 20'd3, 8'h05, 64'h11223344, "wr3_bytes", lat);
    access(0, 20'd3, 8'h00, 64'h0, "rd3", lat);
    checks++; if (dout_a !== 48'h0000_AA22CC44) begin failures++; $display("FAIL byte_merge got=%h exp=0000aa22cc44", dout_a); end
  endtask

  task automatic test_out_of_range;
    int lat;
    access(0, 20'd127, 8'h0F, 64'h7F7F7F7F, "wr127", lat);
    access(0, 20'd0, 8'h0F, 64'h01010101, "wr0", lat);
    access(0, 20'd128, 8'h00, 64'h0, "rd128_oor", lat);
    checks++; if (dout_a !== 48'h0 || err_a !== 1'b1) begin failures++; $display("FAIL oor_read douta=%h err=%b exp 0/1", dout_a, err_a); end
    access(0, 20'hFFFFF, 8'h0F, 64'hFFFFFFFF, "wrFFFFF_oor", lat);
    access(0, 20'd127, 8'h00, 64'h0, "rd127_after_oor", lat);
    access(0, 20'd0, 8'h00, 64'h0, "rd0_after_oor", lat);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL inrange_err got=%b exp=0", err_a); end
  endtask

  task automatic test_back_to_back;
    logic [4:0] pat;
    pat = '0;
    for (int k = 0; k < 3; k++) expect_push(0, 20'd5, 8'h00, 64'h0, "b2b_rd5");
    @(negedge clk); drive(0, 1'b1, 20'd5, 8'h00, 64'h0);
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i >= 1) pat[i-1] = ack_a;
      if (i == 4) req_a = 1'b0;
    end
    checks++; if (pat !== 5'b10101) begin failures++; $display("FAIL b2b_ack_pattern got=%b exp=10101", pat); end
  endtask

  task automatic test_wait_states;
    int lat;
    logic [3:0] ack_pat;
    logic busy_ok;
    access(1, 20'd10, 8'h0F, 64'h5A5A1234, "b_wr10", lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wait_latency got=%0d exp=4", lat); end
    expect_push(1, 20'd10, 8'h00, 64'h0, "b_rd10");
    @(negedge clk); drive(1, 1'b1, 20'd10, 8'h00, 64'h0);
    @(negedge clk); drive(1, 1'b0, 20'd10, 8'h00, 64'h0);
    busy_ok = busy_b;
    ack_pat = '0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      busy_ok &= busy_b;
      ack_pat[i-1] = ack_b;
      if (i == 1) req_b = 1'b1;
      if (i == 2) req_b = 1'b0;
    end
    checks++; if (ack_pat !== 4'b1000) begin failures++; $display("FAIL wait_ack_timing got=%b exp=1000", ack_pat); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL wait_busy_hold got=%b exp=1", busy_ok); end
    checks++; if (dout_b !== 48'h0000_5A5A1234) begin failures++; $display("FAIL wait_rd_value got=%h exp=00005a5a1234", dout_b); end
    @(posedge clk); #1;
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL wait_busy_fall got=%b exp=0", busy_b); end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    access(2, 20'd7, 8'hFF, 64'hCAFEF00D_0BADBEEF, "c_wr7", lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL c_latency got=%0d exp=6", lat); end
    @(negedge clk); drive(2, 1'b1, 20'd7, 8'hFF, 64'h12345678);
    @(negedge clk); drive(2, 1'b0, 20'd7, 8'hFF, 64'h12345678);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack_c !== 1'b0 || busy_c !== 1'b0) begin failures++; $display("FAIL abort_flags ack=%b busy=%b exp 0/0", ack_c, busy_c); end
    checks++; if (dout_c !== 64'h0) begin failures++; $display("FAIL abort_douta got=%h exp=0", dout_c); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) last_m[i] = 64'h0;
    repeat (10) @(posedge clk);
    access(2, 20'd7, 8'h00, 64'h0, "c_rd7_after_abort", lat);
    checks++; if (dout_c !== 64'hCAFEF00D_0BADBEEF) begin failures++; $display("FAIL abort_no_write got=%h exp=cafef00d0badbeef", dout_c); end
  endtask

  task automatic test_param;
    int lat;
    access(2, 20'd15, 8'hFF, 64'h01234567_89ABCDEF, "c_wr15", lat);
    access(2, 20'd15, 8'h00, 64'h0, "c_rd15", lat);
    checks++; if (dout_c !== 64'h01234567_89ABCDEF || err_c !== 1'b0) begin failures++; $display("FAIL wide_rd got=%h err=%b exp=0123456789abcdef/0", dout_c, err_c); end
    access(2, 20'd16, 8'h00, 64'h0, "c_rd16_oor", lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 20'd0, 8'h0, 64'h0);
    drive(1, 1'b0, 20'd0, 8'h0, 64'h0);
    drive(2, 1'b0, 20'd0, 8'h0, 64'h0);
    test_reset();
    test_basic_rw();
    test_byte_write();
    test_out_of_range();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    test_param();
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
